// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared types and default sizes for the multi-port register file.
//   state_e      : sequencer state (CLEAR while zeroing the array, RUN after)
//   DEF_WIDTH    : default data width
//   DEF_ADDR_W   : default register address width
// ---------------------------------------------------------------------------
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_ADDR_W = 5;

endpackage

// File: rtl/regfile_if.sv
// ---------------------------------------------------------------------------
// regfile_if
// Bus bundle between the datapath and the register file.
//   wr_en/wr_addr/wr_data : writeback port
//   rd_addr / rd_data     : NUM_RD packed read ports, port p at
//                           [p*ADDR_W +: ADDR_W] / [p*WIDTH +: WIDTH]
//   dbg_addr / dbg_data   : registered monitor read port
//   init_busy             : high while the array is being cleared
// master = datapath side, slave = register file side.
// ---------------------------------------------------------------------------
interface regfile_if
    import regfile_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = 2
) ();

    logic                       wr_en;
    logic [ADDR_W-1:0]          wr_addr;
    logic [WIDTH-1:0]           wr_data;
    logic [NUM_RD*ADDR_W-1:0]   rd_addr;
    logic [NUM_RD*WIDTH-1:0]    rd_data;
    logic [ADDR_W-1:0]          dbg_addr;
    logic [WIDTH-1:0]           dbg_data;
    logic                       init_busy;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr, dbg_addr,
        input  rd_data, dbg_data, init_busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr, dbg_addr,
        output rd_data, dbg_data, init_busy
    );

endinterface

// File: rtl/regfile_read_port.sv
// ---------------------------------------------------------------------------
// regfile_read_port
// One combinational read port of the register file.
//   state    : sequencer state; nothing is visible while clearing
//   rd_addr  : register address for this port
//   regs     : the register array
//   wr_en/wr_addr/wr_data : current write bus, used for same-cycle bypass
//   rd_data  : read result
// Priority: clearing -> 0, hardwired r0 -> 0, write bypass, array value.
// ---------------------------------------------------------------------------
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_REGS = 32,
    parameter int ZERO_REG = 1
) (
    input  state_e            state,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [WIDTH-1:0]  regs [NUM_REGS],
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    output logic [WIDTH-1:0]  rd_data
);

    logic wr_legal;

    // A write to r0 never lands when r0 is hardwired, so it must not bypass.
    assign wr_legal = wr_en && ((ZERO_REG == 0) || (wr_addr != '0));

    always_comb begin
        rd_data = regs[rd_addr];
        if (state != RUN) begin
            rd_data = '0;
        end else if ((ZERO_REG != 0) && (rd_addr == '0)) begin
            rd_data = '0;
        end else if (wr_legal && (wr_addr == rd_addr)) begin
            rd_data = wr_data;
        end
    end

endmodule

// File: rtl/regfile_multiport.sv
// ---------------------------------------------------------------------------
// regfile_multiport
// Parametrised register file with NUM_RD bypassing read ports, optional
// hardwired-zero r0, a registered debug port and a post-reset clear
// sequencer that zeroes one entry per cycle.
//   clk   : clock, all state on rising edge
//   reset : synchronous, active-high; restarts the clear sequence
//   bus   : regfile_if slave (write port, read ports, debug, init_busy)
// The array itself is never reset in parallel; it is cleared by the
// sequencer, which keeps it inferable as RAM/LUT storage.
// ---------------------------------------------------------------------------
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic     clk,
    input  logic     reset,
    regfile_if.slave bus
);

    // One extra bit so the counter can reach NUM_REGS without wrapping.
    localparam logic [ADDR_W:0] CLR_LAST = (ADDR_W+1)'(NUM_REGS - 1);
    localparam logic [ADDR_W:0] CLR_ONE  = (ADDR_W+1)'(1);

    logic [WIDTH-1:0]  regs_q [NUM_REGS];

    state_e            state_q, state_d;
    logic [ADDR_W:0]   clr_cnt_q, clr_cnt_d;
    logic [WIDTH-1:0]  dbg_data_q, dbg_data_d;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [WIDTH-1:0]  mem_wdata;
    logic              wr_legal;

    assign wr_legal = bus.wr_en && ((ZERO_REG == 0) || (bus.wr_addr != '0));

    // Sequencer, array write mux and debug capture.
    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        dbg_data_d = '0;
        mem_we     = 1'b0;
        mem_waddr  = bus.wr_addr;
        mem_wdata  = bus.wr_data;
        if (reset) begin
            state_d   = CLEAR;
            clr_cnt_d = '0;
        end else begin
            case (state_q)
                CLEAR: begin
                    mem_we    = 1'b1;
                    mem_waddr = clr_cnt_q[ADDR_W-1:0];
                    mem_wdata = '0;
                    clr_cnt_d = clr_cnt_q + CLR_ONE;
                    if (clr_cnt_q == CLR_LAST) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    mem_we     = wr_legal;
                    // Debug port sees the pre-write array value, no bypass.
                    dbg_data_d = regs_q[bus.dbg_addr];
                end
                default: begin
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        state_q    <= state_d;
        clr_cnt_q  <= clr_cnt_d;
        dbg_data_q <= dbg_data_d;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            regs_q[mem_waddr] <= mem_wdata;
        end
    end

    logic [WIDTH-1:0] rd_word [NUM_RD];

    generate
        for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
            regfile_read_port #(
                .WIDTH    (WIDTH),
                .ADDR_W   (ADDR_W),
                .NUM_REGS (NUM_REGS),
                .ZERO_REG (ZERO_REG)
            ) u_rd (
                .state   (state_q),
                .rd_addr (bus.rd_addr[gi*ADDR_W +: ADDR_W]),
                .regs    (regs_q),
                .wr_en   (bus.wr_en),
                .wr_addr (bus.wr_addr),
                .wr_data (bus.wr_data),
                .rd_data (rd_word[gi])
            );
            assign bus.rd_data[gi*WIDTH +: WIDTH] = rd_word[gi];
        end
    endgenerate

    assign bus.dbg_data  = dbg_data_q;
    assign bus.init_busy = (state_q == CLEAR);

endmodule

// File: tb/tb_regfile_multiport.sv
// ---------------------------------------------------------------------------
// tb_regfile_multiport
// Directed bench for regfile_multiport. Two builds run side by side on the
// same clock/reset/write stimulus:
//   dut_a : NUM_RD=4, ZERO_REG=1
//   dut_b : NUM_RD=2, ZERO_REG=0
// ---------------------------------------------------------------------------
module tb_regfile_multiport;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    regfile_if #(.WIDTH(32), .ADDR_W(5), .NUM_RD(4)) ifa ();
    regfile_if #(.WIDTH(32), .ADDR_W(5), .NUM_RD(2)) ifb ();

    regfile_multiport #(
        .WIDTH(32), .ADDR_W(5), .NUM_REGS(32), .NUM_RD(4), .ZERO_REG(1)
    ) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa)
    );

    regfile_multiport #(
        .WIDTH(32), .ADDR_W(5), .NUM_REGS(32), .NUM_RD(2), .ZERO_REG(0)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s got=%h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input logic en, input logic [4:0] addr, input logic [31:0] data);
        ifa.wr_en   = en;
        ifa.wr_addr = addr;
        ifa.wr_data = data;
        ifb.wr_en   = en;
        ifb.wr_addr = addr;
        ifb.wr_data = data;
    endtask

    task automatic set_rd_all(input logic [4:0] addr);
        ifa.rd_addr = {4{addr}};
        ifb.rd_addr = {2{addr}};
    endtask

    function automatic logic [31:0] rda(input int p);
        return ifa.rd_data[p*32 +: 32];
    endfunction

    function automatic logic [31:0] rdb(input int p);
        return ifb.rd_data[p*32 +: 32];
    endfunction

    initial begin
        reset = 1'b1;
        set_wr(1'b0, 5'd0, 32'h0);
        set_rd_all(5'd0);
        ifa.dbg_addr = 5'd3;
        ifb.dbg_addr = 5'd3;

        // Reset state.
        tick();
        tick();
        chk("rst_busy", {31'b0, ifa.init_busy}, 32'd1);
        chk("rst_dbg", ifa.dbg_data, 32'h0);
        for (int p = 0; p < 4; p++) chk($sformatf("rst_rd%0d", p), rda(p), 32'h0);

        // Clear sequence with a write attempt to r3 on every CLEAR edge.
        reset = 1'b0;
        set_wr(1'b1, 5'd3, 32'h1);
        set_rd_all(5'd3);
        for (int i = 0; i < 32; i++) begin
            #1;
            chk($sformatf("clr_busy_e%0d", i), {31'b0, ifa.init_busy}, 32'd1);
            if (i == 5 || i == 31) begin
                chk($sformatf("clr_rd_e%0d", i), rda(0), 32'h0);
                chk($sformatf("clr_rdb_e%0d", i), rdb(1), 32'h0);
                chk($sformatf("clr_dbg_e%0d", i), ifa.dbg_data, 32'h0);
            end
            tick();
        end
        set_wr(1'b0, 5'd0, 32'h0);
        #1;
        chk("clr_done_busy", {31'b0, ifa.init_busy}, 32'd0);
        chk("clr_done_busy_b", {31'b0, ifb.init_busy}, 32'd0);
        chk("clr_r3_a", rda(3), 32'h0);
        chk("clr_r3_b", rdb(0), 32'h0);

        // Every address reads 0 after the clear.
        for (int a = 0; a < 32; a++) begin
            set_rd_all(5'(a));
            #1;
            chk($sformatf("sweep_a_r%0d", a), rda(0), 32'h0);
            chk($sformatf("sweep_b_r%0d", a), rdb(1), 32'h0);
        end

        // Write r5 with same-cycle bypass and debug readback.
        set_wr(1'b1, 5'd5, 32'hDEADBEEF);
        ifa.rd_addr = {5'd6, 5'd6, 5'd6, 5'd5};
        ifa.dbg_addr = 5'd5;
        #1;
        chk("wr5_bypass", rda(0), 32'hDEADBEEF);
        chk("wr5_other_port", rda(1), 32'h0);
        tick();
        set_wr(1'b0, 5'd0, 32'h0);
        #1;
        chk("wr5_array", rda(0), 32'hDEADBEEF);
        chk("wr5_dbg_prewrite", ifa.dbg_data, 32'h0);
        tick();
        chk("wr5_dbg", ifa.dbg_data, 32'hDEADBEEF);

        // r0 hardwired in dut_a, ordinary in dut_b.
        set_wr(1'b1, 5'd0, 32'h12345678);
        set_rd_all(5'd0);
        #1;
        for (int p = 0; p < 4; p++) chk($sformatf("r0_a_same_p%0d", p), rda(p), 32'h0);
        chk("r0_b_same", rdb(0), 32'h12345678);
        tick();
        set_wr(1'b0, 5'd0, 32'h0);
        #1;
        for (int p = 0; p < 4; p++) chk($sformatf("r0_a_next_p%0d", p), rda(p), 32'h0);
        chk("r0_b_next", rdb(1), 32'h12345678);

        // All four ports on r7 while it is being overwritten.
        set_wr(1'b1, 5'd7, 32'hA5A5A5A5);
        tick();
        set_wr(1'b0, 5'd0, 32'h0);
        set_rd_all(5'd7);
        #1;
        for (int p = 0; p < 4; p++) chk($sformatf("r7_old_p%0d", p), rda(p), 32'hA5A5A5A5);
        set_wr(1'b1, 5'd7, 32'h5A5A5A5A);
        #1;
        for (int p = 0; p < 4; p++) chk($sformatf("r7_byp_p%0d", p), rda(p), 32'h5A5A5A5A);
        tick();
        set_wr(1'b0, 5'd0, 32'h0);
        #1;
        for (int p = 0; p < 4; p++) chk($sformatf("r7_new_p%0d", p), rda(p), 32'h5A5A5A5A);

        // Reset with a simultaneous write: reset wins.
        reset = 1'b1;
        set_wr(1'b1, 5'd9, 32'hCAFEF00D);
        tick();
        set_wr(1'b0, 5'd0, 32'h0);
        reset = 1'b0;
        #1;
        chk("rstwr_busy", {31'b0, ifa.init_busy}, 32'd1);
        chk("rstwr_rd", rda(0), 32'h0);

        // Abort the clear at clr_cnt = 10, then require a full 32 edges.
        for (int i = 0; i < 10; i++) tick();
        chk("abort_busy", {31'b0, ifa.init_busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            #1;
            if (i == 0 || i == 10 || i == 20 || i == 31)
                chk($sformatf("restart_busy_e%0d", i), {31'b0, ifa.init_busy}, 32'd1);
            tick();
        end
        #1;
        chk("restart_done", {31'b0, ifa.init_busy}, 32'd0);
        set_rd_all(5'd9);
        #1;
        chk("restart_r9_a", rda(2), 32'h0);
        chk("restart_r9_b", rdb(0), 32'h0);
        set_rd_all(5'd7);
        #1;
        chk("restart_r7_a", rda(3), 32'h0);

        // First legal write right after the clear.
        set_wr(1'b1, 5'd12, 32'h00C0FFEE);
        tick();
        set_wr(1'b0, 5'd0, 32'h0);
        set_rd_all(5'd12);
        #1;
        chk("post_wr12_a", rda(1), 32'h00C0FFEE);
        chk("post_wr12_b", rdb(1), 32'h00C0FFEE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
